cb_cfg: RTL and testbench

CB_CFG -- requirements
Module: cb_cfg

---
 rtl/cb_pkg.sv | 26 ++
 rtl/cb_pin_mux.sv | 26 ++
 rtl/cb_cfg.sv | 144 ++++++++++++++
 tb/tb_cb_cfg.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cb_pkg.sv
// Shared types and size helpers for the connection-box configuration block.
package cb_pkg;

    // Configuration loader states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } cb_state_e;

    // Selector width: codes 0 (none), 1..W (right tracks), W+1..2W (left tracks).
    function automatic int unsigned cb_sel_bits(input int unsigned w);
        return $clog2(2 * w + 1);
    endfunction

    // Frame length: one selector per CLB pin plus one pass enable per track.
    function automatic int unsigned cb_cfg_bits(input int unsigned w, input int unsigned n_clb);
        return n_clb * cb_sel_bits(w) + w;
    endfunction

    // Bit counter width, wide enough to hold the full frame length.
    function automatic int unsigned cb_cnt_bits(input int unsigned w, input int unsigned n_clb);
        return $clog2(cb_cfg_bits(w, n_clb) + 1);
    endfunction

endpackage

// File: rtl/cb_pin_mux.sv
// Per-pin track selector: 0 selects constant 0, 1..W a right track,
// W+1..2W a left track; any larger code also yields 0.
module cb_pin_mux #(
    parameter int unsigned W        = 2,
    parameter int unsigned SEL_BITS = 3
) (
    input  logic [W-1:0]        ri,
    input  logic [W-1:0]        li,
    input  logic [SEL_BITS-1:0] sel,
    output logic                pin_c
);

    // Decode the selector against every legal track code.
    always_comb begin
        pin_c = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (sel == SEL_BITS'(i + 1)) begin
                pin_c = ri[i];
            end
            if (sel == SEL_BITS'(W + i + 1)) begin
                pin_c = li[i];
            end
        end
    end

endmodule

// File: rtl/cb_cfg.sv
// Connection box with serial configuration chain.
// A frame is shifted LSB first into a shadow register and copied to the
// active register in one COMMIT cycle, so routing never sees a partial frame.
// Optional build macro CB_OUT_REG_EN: register ro/lo/clb (one cycle latency).
module cb_cfg
    import cb_pkg::*;
#(
    parameter int unsigned W     = 2,
    parameter int unsigned N_CLB = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     ri,
    input  logic [W-1:0]     li,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic             cfg_din,
    output logic             cfg_dout,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic [W-1:0]     ro,
    output logic [W-1:0]     lo,
    output logic [N_CLB-1:0] clb
);

    localparam int unsigned SEL_BITS = cb_sel_bits(W);
    localparam int unsigned CFG_BITS = cb_cfg_bits(W, N_CLB);
    localparam int unsigned CNT_W    = cb_cnt_bits(W, N_CLB);
    localparam int unsigned PASS_LSB = N_CLB * SEL_BITS;

    cb_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     cnt_base;
    logic [CFG_BITS-1:0]  shadow_q, shadow_d;
    logic [CFG_BITS-1:0]  active_q, active_d;

    logic [N_CLB-1:0]     clb_c;
    logic [W-1:0]         ro_c;
    logic [W-1:0]         lo_c;
    logic [W-1:0]         pass_en;

    // Loader state, counter, shadow and active registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    // Next-state logic: a start inside SHIFT restarts the count, and a bit
    // arriving in the same cycle becomes bit 0 of the new frame.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cnt_base = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                cnt_base = cfg_start ? '0 : cnt_q;
                cnt_d    = cnt_base;
                if (cfg_valid) begin
                    shadow_d = {cfg_din, shadow_q[CFG_BITS-1:1]};
                    cnt_d    = cnt_base + CNT_W'(1);
                    if (cnt_base == CNT_W'(CFG_BITS - 1)) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                active_d = shadow_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status decoded straight from the loader registers.
    assign cfg_dout = shadow_q[0];
    assign cfg_busy = (state_q != IDLE);
    assign cfg_done = (state_q == COMMIT);

    // One selector per CLB pin, each fed by its field of the active frame.
    for (genvar k = 0; k < N_CLB; k++) begin : g_pin
        cb_pin_mux #(
            .W        (W),
            .SEL_BITS (SEL_BITS)
        ) u_pin_mux (
            .ri    (ri),
            .li    (li),
            .sel   (active_q[k*SEL_BITS +: SEL_BITS]),
            .pin_c (clb_c[k])
        );
    end

    // Pass-through tracks cross the box in both directions when enabled.
    assign pass_en = active_q[PASS_LSB +: W];
    assign ro_c    = li & pass_en;
    assign lo_c    = ri & pass_en;

`ifdef CB_OUT_REG_EN
    logic [N_CLB-1:0] clb_q;
    logic [W-1:0]     ro_q;
    logic [W-1:0]     lo_q;

    // Retime the routed outputs by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            clb_q <= '0;
            ro_q  <= '0;
            lo_q  <= '0;
        end else begin
            clb_q <= clb_c;
            ro_q  <= ro_c;
            lo_q  <= lo_c;
        end
    end

    assign clb = clb_q;
    assign ro  = ro_q;
    assign lo  = lo_q;
`else
    assign clb = clb_c;
    assign ro  = ro_c;
    assign lo  = lo_c;
`endif

endmodule

// File: tb/tb_cb_cfg.sv
// Self-checking bench for cb_cfg: directed frame scenarios plus random
// traffic, all checked every cycle against a queue-based reference model.
module tb_cb_cfg;

    localparam int W     = 2;
    localparam int N_CLB = 2;
    localparam int SB    = 3;
    localparam int CFG   = N_CLB * SB + W;

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     ri;
    logic [W-1:0]     li;
    logic             cfg_start;
    logic             cfg_valid;
    logic             cfg_din;
    logic             cfg_dout;
    logic             cfg_busy;
    logic             cfg_done;
    logic [W-1:0]     ro;
    logic [W-1:0]     lo;
    logic [N_CLB-1:0] clb;

    always #5 clk = ~clk;

    cb_cfg #(
        .W     (W),
        .N_CLB (N_CLB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ri        (ri),
        .li        (li),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_din   (cfg_din),
        .cfg_dout  (cfg_dout),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .ro        (ro),
        .lo        (lo),
        .clb       (clb)
    );

    int n_checks = 0;
    int n_errors = 0;
    int done_seen = 0;
    bit chk_en = 1'b0;

    // Reference model: the last CFG accepted bits (oldest first = shadow LSB).
    bit             hist[$];
    logic [CFG-1:0] m_active;
    int             m_count;
    bit             m_loading;
    bit             m_committing;
    logic [N_CLB-1:0] m_clb_r;
    logic [W-1:0]     m_ro_r;
    logic [W-1:0]     m_lo_r;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CFG-1:0] shadow_vec();
        logic [CFG-1:0] v;
        for (int j = 0; j < CFG; j++) v[j] = hist[j];
        return v;
    endfunction

    // CLB pin k follows its selector code with plain range arithmetic.
    function automatic logic [N_CLB-1:0] ref_clb(input logic [CFG-1:0] act,
                                                 input logic [W-1:0] r, input logic [W-1:0] l);
        logic [N_CLB-1:0] v;
        for (int k = 0; k < N_CLB; k++) begin
            logic [CFG-1:0] t;
            int s;
            t = act >> (k * SB);
            s = int'(t[SB-1:0]);
            if (s >= 1 && s <= W)          v[k] = r[s-1];
            else if (s > W && s <= 2 * W)  v[k] = l[s-W-1];
            else                           v[k] = 1'b0;
        end
        return v;
    endfunction

    function automatic logic [W-1:0] ref_pass(input logic [CFG-1:0] act);
        logic [CFG-1:0] t;
        t = act >> (N_CLB * SB);
        return t[W-1:0];
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int j = 0; j < CFG; j++) hist.push_back(1'b0);
        m_active = '0;
        m_count = 0;
        m_loading = 1'b0;
        m_committing = 1'b0;
        m_clb_r = '0;
        m_ro_r = '0;
        m_lo_r = '0;
    endtask

    // Advance the model by one clock with the inputs just applied.
    task automatic model_update(input bit r, input bit st, input bit v, input bit d,
                                input logic [W-1:0] rv, input logic [W-1:0] lv);
        if (r) begin
            model_reset();
        end else begin
            m_clb_r = ref_clb(m_active, rv, lv);
            m_ro_r  = lv & ref_pass(m_active);
            m_lo_r  = rv & ref_pass(m_active);
            if (m_committing) begin
                m_active = shadow_vec();
                m_committing = 1'b0;
            end else if (m_loading) begin
                if (st) m_count = 0;
                if (v) begin
                    hist.push_back(d);
                    void'(hist.pop_front());
                    m_count++;
                    if (m_count == CFG) begin
                        m_loading = 1'b0;
                        m_committing = 1'b1;
                    end
                end
            end else if (st) begin
                m_loading = 1'b1;
                m_count = 0;
            end
        end
    endtask

    // Apply inputs just after a rising edge, check mid-cycle, then clock.
    task automatic cycle(input bit r, input bit st, input bit v, input bit d,
                         input logic [W-1:0] rv, input logic [W-1:0] lv);
        logic [N_CLB-1:0] e_clb;
        logic [W-1:0] e_ro;
        logic [W-1:0] e_lo;
        rst = r; cfg_start = st; cfg_valid = v; cfg_din = d; ri = rv; li = lv;
        #4;
        if (chk_en) begin
`ifdef CB_OUT_REG_EN
            e_clb = m_clb_r; e_ro = m_ro_r; e_lo = m_lo_r;
`else
            e_clb = ref_clb(m_active, rv, lv);
            e_ro  = lv & ref_pass(m_active);
            e_lo  = rv & ref_pass(m_active);
`endif
            check("clb", 32'(clb), 32'(e_clb));
            check("ro", 32'(ro), 32'(e_ro));
            check("lo", 32'(lo), 32'(e_lo));
            check("busy", 32'(cfg_busy), 32'(m_loading | m_committing));
            check("done", 32'(cfg_done), 32'(m_committing));
            check("dout", 32'(cfg_dout), 32'(hist[0]));
        end
        if (cfg_done === 1'b1) done_seen++;
        @(posedge clk);
        model_update(r, st, v, d, rv, lv);
        chk_en = 1'b1;
        #1;
    endtask

    // Start pulse, CFG valid bits LSB first (optional gap), then the commit cycle.
    task automatic send_frame(input logic [CFG-1:0] val, input int gap_at, input int gap_len,
                              input logic [W-1:0] rv, input logic [W-1:0] lv);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, rv, lv);
        for (int i = 0; i < CFG; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    cycle(1'b0, 1'b0, 1'b0, 1'b1, rv, lv);
                    check("gap_cnt_hold", 32'(dut.cnt_q), 32'(gap_at));
                end
            end
            cycle(1'b0, 1'b0, 1'b1, val[i], rv, lv);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, rv, lv);
    endtask

    initial begin
        model_reset();
        rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_din = 1'b0;
        ri = '0; li = '0;
        @(posedge clk);
        #1;

        // Reset, then idle with all tracks driven high.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 2'b11);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 2'b11);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 2'b11);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b11);
        check("rst_clb", 32'(clb), 32'd0);
        check("rst_ro", 32'(ro), 32'd0);
        check("rst_lo", 32'(lo), 32'd0);
        check("rst_busy", 32'(cfg_busy), 32'd0);
        check("rst_active", 32'(dut.active_q), 32'd0);

        // Gap-free load: sel0=1, sel1=4, pass=11.
        done_seen = 0;
        send_frame(8'b11_100_001, -1, 0, 2'b01, 2'b10);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10);
        check("frame_done_cnt", 32'(done_seen), 32'd1);
        check("frame_active", 32'(dut.active_q), 32'hE1);
        check("frame_clb", 32'(clb), 32'd3);
        check("frame_ro", 32'(ro), 32'd2);
        check("frame_lo", 32'(lo), 32'd1);

        // Same frame with a 3-cycle valid gap after 4 bits, from a clean reset.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10);
        done_seen = 0;
        send_frame(8'b11_100_001, 4, 3, 2'b01, 2'b10);
        check("gap_active", 32'(dut.active_q), 32'hE1);
        check("gap_done_cnt", 32'(done_seen), 32'd1);

        // Abandon after 5 bits via a fresh start, then a full new frame.
        done_seen = 0;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b01);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 2'b01);
        send_frame(8'h5A, -1, 0, 2'b10, 2'b01);
        check("restart_active", 32'(dut.active_q), 32'h5A);
        check("restart_done_cnt", 32'(done_seen), 32'd1);

        // Reset four bits into a frame: nothing commits, active clears.
        done_seen = 0;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 2'b11);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 2'b11);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 2'b11);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 2'b11);
        check("abort_done_cnt", 32'(done_seen), 32'd0);
        check("abort_active", 32'(dut.active_q), 32'd0);
        check("abort_clb", 32'(clb), 32'd0);
        check("abort_ro", 32'(ro), 32'd0);
        check("abort_lo", 32'(lo), 32'd0);

        // Out-of-range selector on pin 0 (sel0=7, sel1=0, pass=11).
        send_frame(8'b11_000_111, -1, 0, 2'b11, 2'b11);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b11);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b11);
        check("oor_clb0", 32'(clb[0]), 32'd0);
        check("oor_ro", 32'(ro), 32'd3);
`ifdef CB_OUT_REG_EN
        // Outputs must hold for the cycle the tracks drop, then follow.
        ri = 2'b00; li = 2'b00;
        #4;
        check("lag_hold_ro", 32'(ro), 32'd3);
        check("lag_hold_lo", 32'(lo), 32'd3);
        @(posedge clk);
        model_update(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        #1;
        check("lag_upd_ro", 32'(ro), 32'd0);
        check("lag_upd_lo", 32'(lo), 32'd0);
`endif

        // Random traffic with occasional restarts and resets.
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(79) == 0), ($urandom_range(9) == 0),
                  1'($urandom_range(1)), 1'($urandom_range(1)),
                  2'($urandom_range(3)), 2'($urandom_range(3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
